// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: bundles the two request channels, the result channel and the
// shift-register control/feedback signals of shift_sequencer.
//   req0_* / req1_* : valid/ready request channels carrying operand, shift amount and mode
//   res_*           : valid/ready result channel with owning-requester tag
//   sr_*            : control to (enable/mode/in) and feedback from (out) the shift register
// Modports:
//   slave  : the sequencer's view
//   master : the environment's view (requesters, result consumer, shift register)
interface shift_sequencer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = $clog2(WIDTH) + 1
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic [AMT_W-1:0] req0_amt;
  logic             req0_mode;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic [AMT_W-1:0] req1_amt;
  logic             req1_mode;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_tag;

  logic             sr_enable;
  logic             sr_mode;
  logic [WIDTH-1:0] sr_in;
  logic [WIDTH-1:0] sr_out;

  modport slave (
    input  req0_valid, req0_data, req0_amt, req0_mode,
    input  req1_valid, req1_data, req1_amt, req1_mode,
    input  res_ready, sr_out,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_tag,
    output sr_enable, sr_mode, sr_in
  );

  modport master (
    output req0_valid, req0_data, req0_amt, req0_mode,
    output req1_valid, req1_data, req1_amt, req1_mode,
    output res_ready, sr_out,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_tag,
    input  sr_enable, sr_mode, sr_in
  );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: shares one external right shift register between two requesters.
// A multi-bit right shift is done by enabling the register for N consecutive cycles,
// loading the operand on the first cycle and feeding the register output back after.
// Requesters are arbitrated round-robin; results return on a valid/ready channel with
// a tag naming the owning requester.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : shift_sequencer_if.slave (request, result and shift-register signals)
module shift_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
  input logic              clk,
  input logic              rst_n,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [AMT_W-1:0] AmtMax = AMT_W'(WIDTH);

  state_e           state_q;
  logic             last_grant_q;
  logic [AMT_W-1:0] cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             mode_q;
  logic             tag_q;
  logic             first_q;   // first SHIFT cycle: load operand instead of feedback
  logic             bypass_q;  // amt == 0: result is the captured operand
  logic             sr_enable_q;
  logic             sr_mode_q;
  logic             res_valid_q;

  logic             any_valid;
  logic             gnt_idx;
  logic             accept;
  logic [WIDTH-1:0] acc_data;
  logic [AMT_W-1:0] acc_amt;
  logic [AMT_W-1:0] acc_amt_clamped;
  logic             acc_mode;

  // Arbitration: a sole requester wins; on contention the one not granted last wins.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    gnt_idx   = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    accept    = rst_n && (state_q == StIdle) && any_valid;
    acc_data  = gnt_idx ? bus.req1_data : bus.req0_data;
    acc_amt   = gnt_idx ? bus.req1_amt  : bus.req0_amt;
    acc_mode  = gnt_idx ? bus.req1_mode : bus.req0_mode;
    // Shifting further than WIDTH cannot change the result.
    acc_amt_clamped = (acc_amt > AmtMax) ? AmtMax : acc_amt;
  end

  // Ready is gated by rst_n so every output is low while reset is held.
  assign bus.req0_ready = accept & ~gnt_idx;
  assign bus.req1_ready = accept &  gnt_idx;

  assign bus.sr_enable = sr_enable_q;
  assign bus.sr_mode   = sr_mode_q;
  assign bus.res_valid = res_valid_q;

  always_comb begin
    bus.sr_in    = '0;
    bus.res_data = '0;
    bus.res_tag  = 1'b0;
    if (state_q == StShift) begin
      bus.sr_in = first_q ? data_q : bus.sr_out;
    end
    if (state_q == StDone) begin
      // Register is not enabled in DONE, so sr_out holds steady during a stall.
      bus.res_data = bypass_q ? data_q : bus.sr_out;
      bus.res_tag  = tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      data_q       <= '0;
      mode_q       <= 1'b0;
      tag_q        <= 1'b0;
      first_q      <= 1'b0;
      bypass_q     <= 1'b0;
      sr_enable_q  <= 1'b0;
      sr_mode_q    <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            data_q       <= acc_data;
            mode_q       <= acc_mode;
            tag_q        <= gnt_idx;
            last_grant_q <= gnt_idx;
            cnt_q        <= acc_amt_clamped;
            first_q      <= 1'b1;
            if (acc_amt_clamped == '0) begin
              bypass_q    <= 1'b1;
              res_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              bypass_q    <= 1'b0;
              sr_enable_q <= 1'b1;
              sr_mode_q   <= acc_mode;
              state_q     <= StShift;
            end
          end
        end
        StShift: begin
          first_q <= 1'b0;
          cnt_q   <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            sr_enable_q <= 1'b0;
            sr_mode_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // mode_q is kept for completeness of the captured operation; sr_mode_q drives the port.
  logic unused_mode;
  assign unused_mode = mode_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: self-checking bench for shift_sequencer with a behavioural
// right shift register on the sr_* ports and a queue-based result scoreboard.
module tb_shift_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned AMT_W = 5;

  typedef struct packed {
    logic             tag;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Right shift register: no reset, mode 0 arithmetic, mode 1 logical.
  logic [WIDTH-1:0] sr_q;
  always_ff @(posedge clk) begin
    if (bus.sr_enable) begin
      sr_q <= bus.sr_mode ? (bus.sr_in >> 1) : {bus.sr_in[WIDTH-1], bus.sr_in[WIDTH-1:1]};
    end
  end
  assign bus.sr_out = sr_q;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_shift(input logic [WIDTH-1:0] d,
                                                  input logic [AMT_W-1:0] amt,
                                                  input logic mode);
    logic [WIDTH-1:0] r;
    int n;
    r = d;
    n = int'(amt);
    if (n > int'(WIDTH)) n = int'(WIDTH);
    for (int i = 0; i < n; i++) r = mode ? (r >> 1) : {r[WIDTH-1], r[WIDTH-1:1]};
    return r;
  endfunction

  function automatic logic rdy(input int idx);
    return (idx == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  // Never grant both requesters at once.
  always @(negedge clk) begin
    if (rst_n && (bus.req0_ready || bus.req1_ready)) begin
      check_eq("ready_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
    end
  end

  task automatic drive(input int idx, input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a,
                       input logic m);
    if (idx == 0) begin
      bus.req0_data = d; bus.req0_amt = a; bus.req0_mode = m; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_data = d; bus.req1_amt = a; bus.req1_mode = m; bus.req1_valid = 1'b1;
    end
  endtask

  // Wait for requester idx to be granted; push its expected result; take the accept edge.
  task automatic grant(input int idx);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy(idx)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_eq("grant_timeout", 32'd0, 32'd1);
    end else begin
      check_eq("loser_ready", 32'(rdy(1 - idx)), 32'd0);
      e.tag  = idx[0];
      e.data = (idx == 0) ? model_shift(bus.req0_data, bus.req0_amt, bus.req0_mode)
                          : model_shift(bus.req1_data, bus.req1_amt, bus.req1_mode);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (idx == 0) bus.req0_valid = 1'b0;
    else          bus.req1_valid = 1'b0;
  endtask

  // Count cycles and enables until res_valid, then score the result.
  task automatic collect(input string name, input int lat_exp, input int en_exp, input bit hs);
    int   lat;
    int   en;
    bit   got;
    exp_t e;
    lat = 0; en = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (bus.sr_enable) en++;
      if (bus.res_valid) begin
        got = 1'b1;
        break;
      end
    end
    check_eq({name, "_valid"}, 32'(got), 32'd1);
    check_eq({name, "_lat"}, 32'(lat), 32'(lat_exp));
    check_eq({name, "_en_cycles"}, 32'(en), 32'(en_exp));
    if (got) begin
      check_eq({name, "_no_ready_in_done"}, 32'(bus.req0_ready | bus.req1_ready), 32'd0);
      if (sb.size() == 0) begin
        check_eq({name, "_sb_underflow"}, 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq({name, "_data"}, 32'(bus.res_data), 32'(e.data));
        check_eq({name, "_tag"}, 32'(bus.res_tag), 32'(e.tag));
      end
    end
    if (hs) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string name);
    check_eq({name, "_req0_ready"}, 32'(bus.req0_ready), 32'd0);
    check_eq({name, "_req1_ready"}, 32'(bus.req1_ready), 32'd0);
    check_eq({name, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check_eq({name, "_res_data"}, 32'(bus.res_data), 32'd0);
    check_eq({name, "_res_tag"}, 32'(bus.res_tag), 32'd0);
    check_eq({name, "_sr_enable"}, 32'(bus.sr_enable), 32'd0);
    check_eq({name, "_sr_mode"}, 32'(bus.sr_mode), 32'd0);
    check_eq({name, "_sr_in"}, 32'(bus.sr_in), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] hold_data;
    logic             hold_tag;

    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_amt = '0; bus.req0_mode = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_amt = '0; bus.req1_mode = 1'b0;
    bus.res_ready  = 1'b1;

    // Reset state, with both requesters valid to show ready stays low.
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin from reset: req0 first, then req1, twice.
    for (int r = 0; r < 2; r++) begin
      drive(0, 16'h0002, 5'd1, 1'b0);
      drive(1, 16'h8000, 5'd1, 1'b0);
      grant(0);
      collect("rr_a", 2, 1, 1'b1);
      grant(1);
      collect("rr_b", 2, 1, 1'b1);
    end

    drive(0, 16'hF000, 5'd4, 1'b0);
    grant(0);
    collect("arith4", 5, 4, 1'b1);

    drive(1, 16'hF000, 5'd4, 1'b1);
    grant(1);
    collect("logic4", 5, 4, 1'b1);

    drive(0, 16'h1234, 5'd0, 1'b0);
    grant(0);
    collect("bypass", 1, 0, 1'b1);

    drive(1, 16'h8001, 5'd20, 1'b0);
    grant(1);
    collect("clamp_arith", 17, 16, 1'b1);

    drive(0, 16'h8001, 5'd20, 1'b1);
    grant(0);
    collect("clamp_logic", 17, 16, 1'b1);

    // Result stall: outputs hold, no new grant while DONE.
    bus.res_ready = 1'b0;
    drive(0, 16'hA5A5, 5'd3, 1'b1);
    grant(0);
    collect("stall", 4, 3, 1'b0);
    hold_data = bus.res_data;
    hold_tag  = bus.res_tag;
    drive(1, 16'h00FF, 5'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_valid", 32'(bus.res_valid), 32'd1);
      check_eq("stall_data", 32'(bus.res_data), 32'(hold_data));
      check_eq("stall_tag", 32'(bus.res_tag), 32'(hold_tag));
      check_eq("stall_req1_ready", 32'(bus.req1_ready), 32'd0);
    end
    bus.req1_valid = 1'b0;
    bus.res_ready  = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset mid-SHIFT abandons the operation; last_grant was 0 before it.
    drive(0, 16'hF0F0, 5'd8, 1'b0);
    grant(0);
    @(posedge clk);
    #3;
    check_eq("pre_rst_sr_enable", 32'(bus.sr_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    drive(0, 16'h8000, 5'd1, 1'b0);
    drive(1, 16'h8000, 5'd1, 1'b1);
    grant(0);
    collect("post_rst_a", 2, 1, 1'b1);
    grant(1);
    collect("post_rst_b", 2, 1, 1'b1);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Controller that shares one right_shift_register instance between two requesters.
- Performs multi-bit right shifts by driving the register's enable/mode/in ports for N consecutive cycles, feeding the register's output back to its input.
- Arbitrates round-robin between the two requesters and returns each result with a valid/ready handshake and a requester tag.
- Sits between the lab datapath clients and the shift register; the shift register itself is unchanged.

Parameters:
- WIDTH, 16, data width; must match the controlled shift register's width.
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount fields.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_data  input  WIDTH  requester 0 operand.
- req0_amt  input  AMT_W  requester 0 shift amount.
- req0_mode  input  1  requester 0 mode: 0 = arithmetic, 1 = logical.
- req1_valid, req1_ready, req1_data, req1_amt, req1_mode: same as requester 0, for requester 1.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  WIDTH  shifted result.
- res_tag  output  1  requester index that owns the result.
- sr_enable  output  1  to shift register enable.
- sr_mode  output  1  to shift register mode.
- sr_in  output  WIDTH  to shift register in.
- sr_out  input  WIDTH  from shift register out.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; last_grant = 1, so requester 0 wins first.
  - Counter and operand registers cleared.
  - All outputs 0: req*_ready, res_valid, res_data, res_tag, sr_enable, sr_mode, sr_in.
  - The shift register has no reset. Its contents are don't-care because each operation reloads it.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Grant rule: if only one requester is valid, grant it. If both are valid, grant the one that is not last_grant.
  - req*_ready is combinational, high only for the granted requester, and only in IDLE.
  - Accept occurs on the edge where valid & ready. At accept, capture data, mode and the clamped amount, set tag = granted index, and set last_grant = granted index.
  - last_grant changes only on accept.
- Amount clamp: amt > WIDTH is treated as WIDTH, because further shifting cannot change the result.
- amt == 0 (bypass): on accept go to DONE. res_data = captured data. sr_enable is never asserted.
- amt > 0: on accept go to SHIFT with cnt = amt.
- SHIFT:
  - sr_enable = 1 and sr_mode = captured mode.
  - First SHIFT cycle: sr_in = captured data. Later cycles: sr_in = sr_out.
  - cnt decrements each cycle. When cnt == 1, move to DONE at that edge.
  - sr_enable is high for exactly amt (clamped) consecutive cycles.
- DONE:
  - sr_enable = 0, so the register holds.
  - res_valid = 1. res_data = sr_out (shift path) or the captured operand (bypass). res_tag = captured tag.
  - res_data and res_tag stay stable while res_ready is low.
  - On res_valid & res_ready, go to IDLE.
- Back-to-back operations: no accept in the cycle of result handshake, giving a minimum one-cycle bubble.
- Latency from accept edge to res_valid: amt + 1 cycles for amt > 0; 1 cycle for amt == 0.
- Requests deasserted before accept are simply not serviced. Inputs are ignored outside IDLE.
- Reset mid-SHIFT or mid-DONE: the operation is abandoned, no result is produced, and the state is as at reset.

Test Plan:
- req0: data 16'hF000, amt 4, mode 0 -> sr_enable high 4 cycles; res_data 16'hFF00; res_tag 0; res_valid 5 cycles after accept.
- req1: data 16'hF000, amt 4, mode 1 -> res_data 16'h0F00; res_tag 1.
- req0: data 16'h1234, amt 0 -> res_valid 1 cycle after accept; res_data 16'h1234; sr_enable never high.
- Both valid from reset, each with amt 1 -> grants in order req0, req1. Then both valid again -> req0, then req1. Each grant is one accept, and the loser's ready stays low.
- data 16'h8001, amt 20, mode 0 -> enable exactly 16 cycles; res 16'hFFFF. Same with mode 1 -> res 16'h0000.
- res_ready held low 3 cycles -> res_data/res_tag stable, no new ready. Then rst_n pulsed low mid-SHIFT -> all outputs 0 immediately (asynchronous); the next req0 is granted first.
